// File: rtl/quadrant_board_port.sv
// 8x8 Life board with 4x4 quadrant write port and snapshot readout; first word 1 cycle after dump_req.
// Writes never stall; readout words hold while rd_ready is low.
module quadrant_board_port #(
  parameter logic [63:0] RESET_PATTERN = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_pos,
  input  logic [15:0] wr_val,
  input  logic        dump_req,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [1:0]  rd_pos,
  output logic [15:0] rd_val,
  output logic        rd_last,
  output logic        busy,
  output logic [63:0] board
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [63:0] snap;

  // Local cell (lr,lc) lives at val[15-(4*lr+lc)]; pos[1] picks right half, pos[0] bottom half.
  function automatic logic [15:0] get_quad(input logic [63:0] b, input logic [1:0] pos);
    logic [15:0] q;
    int r0, c0;
    q  = '0;
    r0 = pos[0] ? 4 : 0;
    c0 = pos[1] ? 4 : 0;
    for (int lr = 0; lr < 4; lr++)
      for (int lc = 0; lc < 4; lc++)
        q[15 - (4 * lr + lc)] = b[(r0 + lr) * 8 + c0 + lc];
    return q;
  endfunction

  function automatic logic [63:0] set_quad(input logic [63:0] b, input logic [1:0] pos,
                                           input logic [15:0] v);
    logic [63:0] nb;
    int r0, c0;
    nb = b;
    r0 = pos[0] ? 4 : 0;
    c0 = pos[1] ? 4 : 0;
    for (int lr = 0; lr < 4; lr++)
      for (int lc = 0; lc < 4; lc++)
        nb[(r0 + lr) * 8 + c0 + lc] = v[15 - (4 * lr + lc)];
    return nb;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      board <= RESET_PATTERN;
    else if (wr_en)
      board <= set_quad(board, wr_pos, wr_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      snap     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      rd_pos   <= 2'b00;
      rd_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req) begin
            // Pre-edge board: a write in this same cycle is not part of the dump.
            snap     <= board;
            state    <= SEND;
            rd_pos   <= 2'b00;
            rd_val   <= get_quad(board, 2'b00);
            rd_valid <= 1'b1;
            rd_last  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (rd_valid && rd_ready) begin
            if (rd_pos == 2'b11) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              busy     <= 1'b0;
            end else begin
              rd_pos  <= rd_pos + 2'd1;
              rd_val  <= get_quad(snap, rd_pos + 2'd1);
              rd_last <= (rd_pos == 2'b10);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quadrant_board_port.sv
// Directed-vector bench for quadrant_board_port: writes, dumps with and without stalls, reset abort.
module tb_quadrant_board_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_pos;
  logic [15:0] wr_val;
  logic        dump_req;
  logic        rd_valid;
  logic        rd_ready;
  logic [1:0]  rd_pos;
  logic [15:0] rd_val;
  logic        rd_last;
  logic        busy;
  logic [63:0] board;

  int vec_cnt = 0;
  int err_cnt = 0;

  quadrant_board_port dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_pos   (wr_pos),
    .wr_val   (wr_val),
    .dump_req (dump_req),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_pos   (rd_pos),
    .rd_val   (rd_val),
    .rd_last  (rd_last),
    .busy     (busy),
    .board    (board)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] pos, input logic [15:0] val);
    wr_en  = 1'b1;
    wr_pos = pos;
    wr_val = val;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [1:0] pos, input logic [15:0] val);
    chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".busy"},  64'(busy),     64'd1);
    chk({tag, ".pos"},   64'(rd_pos),   64'(pos));
    chk({tag, ".val"},   64'(rd_val),   64'(val));
    chk({tag, ".last"},  64'(rd_last),  64'(pos == 2'b11));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(rd_valid), 64'd0);
    chk({tag, ".busy"},  64'(busy),     64'd0);
    chk({tag, ".last"},  64'(rd_last),  64'd0);
  endtask

  // Full dump; each word is held for 'stall' cycles with rd_ready low before acceptance.
  task automatic dump(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] v3, input int stall);
    logic [15:0] exp_v [4];
    exp_v[0] = v0; exp_v[1] = v1; exp_v[2] = v2; exp_v[3] = v3;
    rd_ready = (stall == 0);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_word($sformatf("%s.w%0d", tag, i), 2'(i), exp_v[i]);
      for (int s = 0; s < stall; s++) begin
        dump_req = 1'b1;  // ignored while streaming
        step();
        dump_req = 1'b0;
        chk_word($sformatf("%s.w%0d.hold%0d", tag, i, s), 2'(i), exp_v[i]);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = (stall == 0);
    end
    chk_idle({tag, ".end"});
    rd_ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_pos   = 2'b00;
    wr_val   = 16'h0;
    dump_req = 1'b0;
    rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst.board", board, 64'h0);
    chk_idle("rst");
    chk("rst.pos", 64'(rd_pos), 64'd0);
    chk("rst.val", 64'(rd_val), 64'd0);

    dump("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

    wr(2'b00, 16'h6E88);
    wr(2'b01, 16'h0000);
    wr(2'b10, 16'h0886);
    wr(2'b11, 16'h033E);
    chk("glider.b0",  64'(board[0]),  64'd0);
    chk("glider.b1",  64'(board[1]),  64'd1);
    chk("glider.b2",  64'(board[2]),  64'd1);
    chk("glider.b8",  64'(board[8]),  64'd1);
    chk("glider.b9",  64'(board[9]),  64'd1);
    chk("glider.b10", 64'(board[10]), 64'd1);
    dump("pat", 16'h6E88, 16'h0000, 16'h0886, 16'h033E, 0);
    dump("stall", 16'h6E88, 16'h0000, 16'h0886, 16'h033E, 3);

    do_reset();
    chk("clr.board", board, 64'h0);
    wr_en  = 1'b1;
    wr_pos = 2'b11;
    wr_val = 16'h8001;
    step();
    wr_en  = 1'b0;
    chk("br.board", board, 64'h8000_0010_0000_0000);

    // Same-cycle write and dump: write lands on board, not in the snapshot.
    do_reset();
    rd_ready = 1'b1;
    dump_req = 1'b1;
    wr_en    = 1'b1;
    wr_pos   = 2'b00;
    wr_val   = 16'hFFFF;
    step();
    dump_req = 1'b0;
    chk_word("race.w0", 2'b00, 16'h0000);
    chk("race.b0", 64'(board[0]), 64'd1);
    wr_pos = 2'b10;
    wr_val = 16'h1234;
    step();
    wr_en  = 1'b0;
    chk_word("race.w1", 2'b01, 16'h0000);
    chk("race.b7", 64'(board[7]), 64'd1);
    step();
    chk_word("race.w2", 2'b10, 16'h0000);
    step();
    chk_word("race.w3", 2'b11, 16'h0000);
    step();
    chk_idle("race.end");

    // Reset while the second word is presented aborts the dump.
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    chk_word("abort.w0", 2'b00, 16'hFFFF);
    step();
    chk_word("abort.w1", 2'b01, 16'h0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("abort.rst");
    chk("abort.board", board, 64'h0);
    step();
    step();
    chk_idle("abort.quiet");
    dump("restart", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
